// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-requester memory port arbiter.
package mem_arb_pkg;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int BANK_W = 8;
    localparam logic [BANK_W-1:0] PROG_BANK = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes plus the shared memory bus; slave = arbiter view, master = requesters/memory.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
);
    logic              r0_req, r0_we, r0_gnt, r0_done;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata, r0_rdata;
    logic              r1_req, r1_we, r1_gnt, r1_done, r1_err;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata, r1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_we, busy;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_done, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_done, r1_rdata, r1_err,
        output mem_addr, mem_wdata, mem_we, busy,
        input  mem_rdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_done, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_done, r1_rdata, r1_err,
        input  mem_addr, mem_wdata, mem_we, busy,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_picker2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
module rr_picker2 (
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_winner ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sequencing one fixed-latency memory transaction at a time.
// Optional BANK0_PROTECT_EN: r1 writes into the program bank are suppressed and flagged.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   bus
);
    import mem_arb_pkg::*;

    state_t            state, state_n;
    logic [3:0]        cnt;
    logic              last_w, cur, cur_we;
    logic [1:0]        req, grant, gnt_q, done_q;
    logic              accept, fin, blk;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata, rdata0, rdata1;

    assign req = {bus.r1_req, bus.r0_req};

    rr_picker2 u_pick (.req(req), .last_winner(last_w), .grant(grant));

    assign win_we    = grant[1] ? bus.r1_we    : bus.r0_we;
    assign win_addr  = grant[1] ? bus.r1_addr  : bus.r0_addr;
    assign win_wdata = grant[1] ? bus.r1_wdata : bus.r0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // DONE behaves like IDLE for acceptance, giving a MEM_LAT+1 back-to-back period.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        fin     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (|req) begin
                    accept  = 1'b1;
                    state_n = ST_ACCESS;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt == 4'd1) begin
                    fin     = 1'b1;
                    state_n = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

`ifdef BANK0_PROTECT_EN
    logic err_q, r1_err_q;
    assign blk = grant[1] && bus.r1_we && (bus.r1_addr[ADDR_W-1 -: BANK_W] == PROG_BANK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= 1'b0;
            r1_err_q <= 1'b0;
        end else begin
            if (accept) err_q <= blk;
            r1_err_q <= fin && cur && err_q;
        end
    end
    assign bus.r1_err = r1_err_q;
`else
    assign blk        = 1'b0;
    assign bus.r1_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            last_w    <= 1'b1;
            cur       <= 1'b0;
            cur_we    <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            gnt_q      <= '0;
            done_q     <= '0;
            bus.mem_we <= 1'b0;
            if (accept) begin
                cnt           <= 4'(MEM_LAT);
                last_w        <= grant[1];
                cur           <= grant[1];
                cur_we        <= win_we;
                gnt_q         <= grant;
                bus.mem_addr  <= win_addr;
                bus.mem_wdata <= win_wdata;
                bus.mem_we    <= win_we & ~blk;
            end else if (state == ST_ACCESS) begin
                cnt <= cnt - 4'd1;
            end
            if (fin) begin
                done_q <= cur ? 2'b10 : 2'b01;
                if (!cur_we) begin
                    if (cur) rdata1 <= bus.mem_rdata;
                    else     rdata0 <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.r0_gnt   = gnt_q[0];
    assign bus.r1_gnt   = gnt_q[1];
    assign bus.r0_done  = done_q[0];
    assign bus.r1_done  = done_q[1];
    assign bus.r0_rdata = rdata0;
    assign bus.r1_rdata = rdata1;
    assign bus.busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: MEM_LAT=1 main instance, MEM_LAT=3 timing instance.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef BANK0_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    mem_bus_arbiter_if b1 ();
    mem_bus_arbiter_if b3 ();

    mem_bus_arbiter #(.MEM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    mem_bus_arbiter #(.MEM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    function automatic logic [15:0] memf(input logic [23:0] a);
        return (a == 24'h000010) ? 16'hBEEF : (a[15:0] ^ 16'hA5A5);
    endfunction
    assign b1.mem_rdata = memf(b1.mem_addr);
    assign b3.mem_rdata = memf(b3.mem_addr);

    typedef struct packed { bit id; logic [15:0] rdata; bit err; } exp_t;
    exp_t        sbq[$];
    bit          gq[$];
    time         gtq[$];
    logic [39:0] weq[$];
    int checks = 0, errors = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done, records grants and write strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (b1.r0_gnt) begin gq.push_back(1'b0); gtq.push_back($time); end
            if (b1.r1_gnt) begin gq.push_back(1'b1); gtq.push_back($time); end
            if (b1.mem_we) weq.push_back({b1.mem_addr, b1.mem_wdata});
            if (b1.r0_done || b1.r1_done) begin
                if (sbq.size() == 0) begin
                    chk("done_unexpected", {b1.r1_done, b1.r0_done}, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_id", {b1.r1_done, b1.r0_done}, e.id ? 2'b10 : 2'b01);
                    chk("rdata", e.id ? b1.r1_rdata : b1.r0_rdata, e.rdata);
                    chk("r1_err", b1.r1_err, e.err);
                end
            end else begin
                chk("err_without_done", b1.r1_err, 0);
            end
        end
    end

    task automatic set_req(input bit id, input bit v, input bit we, input logic [23:0] a, input logic [15:0] d);
        if (id) begin b1.r1_req = v; b1.r1_we = we; b1.r1_addr = a; b1.r1_wdata = d; end
        else    begin b1.r0_req = v; b1.r0_we = we; b1.r0_addr = a; b1.r0_wdata = d; end
    endtask

    task automatic txn(input bit id, input bit we, input logic [23:0] a, input logic [15:0] d);
        logic ok;
        @(posedge clk); #1;
        set_req(id, 1'b1, we, a, d);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            ok = id ? b1.r1_gnt : b1.r0_gnt;
        end
        chk("gnt_seen", ok, 1);
        @(posedge clk); #1;
        set_req(id, 1'b0, we, a, d);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            ok = id ? b1.r1_done : b1.r0_done;
        end
        chk("done_seen", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_req(1'b0, 1'b1, 1'b0, 24'h000100, 16'h0);
        set_req(1'b1, 1'b1, 1'b0, 24'h020200, 16'h0);
        b3.r0_req = 0; b3.r0_we = 0; b3.r0_addr = '0; b3.r0_wdata = '0;
        b3.r1_req = 0; b3.r1_we = 0; b3.r1_addr = '0; b3.r1_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {b1.r0_gnt, b1.r1_gnt, b1.r0_done, b1.r1_done, b1.r1_err, b1.mem_we, b1.busy}, 0);
        chk("rst_bus", {b1.mem_addr, b1.mem_wdata}, 0);
        chk("rst_rdata", {b1.r0_rdata, b1.r1_rdata}, 0);

        // Both requesters held from reset release: strict alternation starting with r0
        sbq.push_back('{1'b0, 16'hA4A5, 1'b0});
        sbq.push_back('{1'b1, 16'hA7A5, 1'b0});
        sbq.push_back('{1'b0, 16'hA4A5, 1'b0});
        sbq.push_back('{1'b1, 16'hA7A5, 1'b0});
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        b1.r0_req = 1'b0; b1.r1_req = 1'b0;
        repeat (2) @(posedge clk);
        chk("rr_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_order", gq[i], i % 2);
        for (int i = 1; i < 4 && i < gtq.size(); i++) chk("rr_spacing", gtq[i] - gtq[i-1], 20);
        gq.delete(); gtq.delete();

        // Single r0 read, exact cycle positions
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 24'h000010, 16'h0);
        sbq.push_back('{1'b0, 16'hBEEF, 1'b0});
        @(posedge clk);
        @(negedge clk);
        chk("t1_gnt", {b1.r0_gnt, b1.r1_gnt}, 2'b10);
        chk("t1_we", b1.mem_we, 0);
        chk("t1_addr", b1.mem_addr, 24'h000010);
        chk("t1_early_done", b1.r0_done, 0);
        @(posedge clk); #1 b1.r0_req = 1'b0;
        @(negedge clk);
        chk("t1_done", b1.r0_done, 1);
        chk("t1_rdata", b1.r0_rdata, 16'hBEEF);

        // r1 write outside the program bank
        weq.delete();
        sbq.push_back('{1'b1, 16'hA7A5, 1'b0});
        txn(1'b1, 1'b1, 24'h010020, 16'h1234);
        @(posedge clk); #1;
        chk("t3_we_count", weq.size(), 1);
        chk("t3_we_bus", weq.size() > 0 ? weq[0] : 40'h0, {24'h010020, 16'h1234});

        // r1 write into the program bank
        weq.delete();
        sbq.push_back('{1'b1, 16'hA7A5, PROT});
        txn(1'b1, 1'b1, 24'h000005, 16'h5555);
        @(posedge clk); #1;
        chk("t6_r1_we_count", weq.size(), PROT ? 0 : 1);

        // r0 write into the program bank always goes through
        weq.delete();
        sbq.push_back('{1'b0, 16'hBEEF, 1'b0});
        txn(1'b0, 1'b1, 24'h000005, 16'h6666);
        @(posedge clk); #1;
        chk("t6_r0_we_count", weq.size(), 1);
        chk("t6_r0_we_bus", weq.size() > 0 ? weq[0] : 40'h0, {24'h000005, 16'h6666});

        // Reset mid-ACCESS drops the transaction; held req is re-granted after release
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 24'h000300, 16'h0);
        @(posedge clk);
        @(negedge clk);
        chk("t5_gnt", b1.r0_gnt, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_ctl", {b1.r0_gnt, b1.r0_done, b1.r1_done, b1.mem_we, b1.busy}, 0);
        chk("t5_rst_addr", b1.mem_addr, 0);
        chk("t5_rst_rdata", b1.r0_rdata, 0);
        @(posedge clk); #1 rst = 1'b0;
        sbq.push_back('{1'b0, 16'hA6A5, 1'b0});
        txn(1'b0, 1'b0, 24'h000300, 16'h0);
        @(posedge clk); #1;

        // MEM_LAT=3 instance: hold, capture point and busy window
        b3.r0_req = 1'b1; b3.r0_addr = 24'h000040;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t4_gnt", b3.r0_gnt, k == 1);
            chk("t4_busy", b3.busy, k <= 4);
            chk("t4_done", b3.r0_done, k == 4);
            if (k <= 3) chk("t4_addr_hold", b3.mem_addr, 24'h000040);
            if (k == 3) chk("t4_rdata_pre", b3.r0_rdata, 0);
            if (k == 4) chk("t4_rdata", b3.r0_rdata, 16'hA5E5);
            if (k == 1) begin @(posedge clk); #1 b3.r0_req = 1'b0; end
        end

        repeat (2) @(posedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
